uart_msg_arbiter: RTL
=====================

# uart_msg_arbiter

Shares the single UART TX message FIFO between several message sources: controller replies, memory-manager "received wrong" notifications and status reports. Each source presents one whole UART message and holds it until acknowledged. The arbiter picks one source at a time by round-robin, with optional fixed priority for source 0, and writes the chosen message into the disassembler FIFO. It sits between the message sources and the `fifo` instance that feeds `msg_disasm`.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters (2..8).
- `MSG_WIDTH`, 32: message width in bits; equals the UART message width.
- `PRIO0`, 0: when 1, requester 0 wins whenever it is valid.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ  bit i high means requester i holds a message.
- `req_msg`  in  NUM_REQ*MSG_WIDTH  requester i message occupies bits [i*MSG_WIDTH +: MSG_WIDTH].
- `req_ack`  out  NUM_REQ  one-cycle pulse on bit i when requester i's message is written.
- `fifo_full`  in  1  full flag of the downstream FIFO.
- `fifo_wr_en`  out  1  one-cycle write strobe to the FIFO.
- `fifo_data`  out  MSG_WIDTH  message presented to the FIFO; registered.
- `busy`  out  1  high while in WRITE.
- `last_grant`  out  $clog2(NUM_REQ)  index of the most recent winner.

## Operation
- The FSM has two states: IDLE and WRITE.
- **IDLE**
  - If `fifo_full` is low and any `req_valid` bit is set, select a winner, latch its `req_msg` into `fifo_data`, set `last_grant` to the winner, and go to WRITE.
  - Otherwise stay in IDLE. `fifo_data` holds its previous value.
- **WRITE** (always exactly one cycle)
  - Assert `fifo_wr_en` and the winner's `req_ack` bit.
  - Ignore `req_valid` and `fifo_full`.
  - Return to IDLE.
- **Winner selection**
  - If `PRIO0`=1 and `req_valid[0]`=1, requester 0 wins.
  - Otherwise search indices starting at `last_grant`+1, wrapping modulo NUM_REQ; the first valid index wins.
  - A priority grant still updates `last_grant` to 0.
- **Requester rules**
  - Hold `req_valid` and `req_msg` stable from assertion until the `req_ack` cycle.
  - `req_valid` sampled in the cycle after the ack counts as a new message.
  - Dropping `req_valid` early is a protocol violation. A message already latched is still written and acked.
- **Full handling**
  - `fifo_full` is sampled only in IDLE.
  - The arbiter is the FIFO's only writer, so the FIFO cannot become full between the decision and the write.
  - No message is ever written while `fifo_full` is high at the decision point.
- `busy` equals (state == WRITE).

## Timing
- Reset values:
  - state IDLE
  - `fifo_wr_en`=0, `req_ack`=0, `busy`=0
  - `fifo_data`=0
  - `last_grant`=NUM_REQ-1, so the first round-robin search starts at 0.
- Latency: if requester i is the winner and `req_valid[i]` rises in cycle T (state IDLE, FIFO not full):
  - cycle T+1: `fifo_data` holds the message, and `fifo_wr_en`=1 and `req_ack[i]`=1.
  - cycle T+2: back in IDLE and able to grant again.
- Peak throughput is one message per 2 cycles.
- `fifo_wr_en` and `req_ack` are never high for two consecutive cycles.
- Exactly one `req_ack` bit is set, and only when `fifo_wr_en` is set.
- Reset asserted in WRITE: the write and ack are suppressed that cycle and all outputs take their reset values the next cycle.
- Simultaneous valid on all requesters (`PRIO0`=0, NUM_REQ=3, from reset): grants occur in order 0,1,2,0,... every 2 cycles.
- `fifo_full` high with requests pending: stay in IDLE with no strobes. Grant in the first cycle `fifo_full` is sampled low.

## Test plan
- **Single request:** after reset, `req_valid`=3'b010 with `req_msg[1]`=32'hDEADBEEF for one message.
  - Required: 1 cycle later `fifo_wr_en`=1, `fifo_data`=32'hDEADBEEF, `req_ack`=3'b010, `last_grant`=1.
- **Round-robin fairness:** `req_valid`=3'b111 held for 12 cycles, messages 32'h0000000A/B/C.
  - Required: 6 writes with data A,B,C,A,B,C; `req_ack` sequence 001,010,100,001,010,100; no back-to-back strobes.
- **Priority mode:** `PRIO0`=1, `req_valid`=3'b111 held.
  - Required: every grant goes to 0 and requesters 1 and 2 are never acked.
  - Then drop `req_valid[0]`: grants go 1,2,1,2.
- **Backpressure:** `fifo_full`=1 for 10 cycles with `req_valid`=3'b100.
  - Required: no `fifo_wr_en` during those cycles.
  - `fifo_full` falls in cycle F: `fifo_wr_en`=1 and `req_ack`=3'b100 in cycle F+1.
- **Reset mid-write:** assert `reset` in the WRITE cycle of a grant to requester 2.
  - Required: no `fifo_wr_en` or `req_ack` that cycle; next cycle `fifo_data`=0 and `last_grant`=2 (NUM_REQ-1).
  - With `req_valid`=3'b111 after reset, the first grant goes to 0.
- **Back-to-back from one source:** requester 0 raises a new `req_valid` in the cycle after its ack, with data 1 then 2.
  - Required: two writes 2 cycles apart, data 1 then 2, no duplicate.

Source files
------------

// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: shares the UART TX message FIFO between message sources.
// Round-robin grant with optional fixed priority for requester 0.
module uart_msg_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MSG_WIDTH = 32,
    parameter int PRIO0     = 0,
    localparam int LG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*MSG_WIDTH-1:0] req_msg,
    output logic [NUM_REQ-1:0]           req_ack,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [MSG_WIDTH-1:0]         fifo_data,
    output logic                         busy,
    output logic [LG_W-1:0]              last_grant
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [MSG_WIDTH-1:0] data_q, data_d;
    logic [LG_W-1:0]      last_q, last_d;
    logic                 wr_q, wr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;

    logic                 found;
    logic [LG_W-1:0]      win;

    // Winner search: requester 0 first in priority mode, else rotate from last grant.
    always_comb begin
        found = 1'b0;
        win   = '0;
        if (PRIO0 == 1 && req_valid[0]) begin
            found = 1'b1;
            win   = '0;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int idx;
                idx = (int'(last_q) + k) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    win   = LG_W'(idx);
                end
            end
        end
    end

    // Next-state and next-output values; WRITE always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        wr_d    = 1'b0;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_full && found) begin
                    state_d    = WRITE;
                    data_d     = req_msg[int'(win)*MSG_WIDTH +: MSG_WIDTH];
                    last_d     = win;
                    wr_d       = 1'b1;
                    ack_d[win] = 1'b1;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; last grant resets to NUM_REQ-1 so search starts at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            last_q  <= LG_W'(NUM_REQ - 1);
            wr_q    <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
        end
    end

    // A reset arriving during WRITE must kill that cycle's strobe and ack.
    assign fifo_wr_en = wr_q & ~reset;
    assign req_ack    = ack_q & {NUM_REQ{~reset}};
    assign fifo_data  = data_q;
    assign last_grant = last_q;
    assign busy       = (state_q == WRITE);

endmodule
